// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle core: jump op encoding, window length
// and the core's default program-counter width.
package cpu_pkg;

    typedef enum logic [2:0] {
        J_NONE = 3'd0,
        J_JMP  = 3'd1,
        J_BEQZ = 3'd2,
        J_BNEZ = 3'd3,
        J_CALL = 3'd4,
        J_RET  = 3'd5
    } jop_t;

    // Cycles per instruction window; phase counts 0..PHASES-1.
    localparam int PHASES = 6;

    // Default program-counter / jump-target width for the core.
    localparam int CPU_D = 12;

endpackage

// File: rtl/ret_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry
// (the pointer simply keeps wrapping) and the count saturates at DEPTH.
// push and pop are never asserted together by the owner.
module ret_stack #(
    parameter int D     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] push_data,
    output logic [D-1:0] top_data,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // ptr is the next slot to write; the newest entry lives at ptr-1.
    logic [PW-1:0] ptr;
    logic [CW-1:0] count;
    logic [D-1:0]  mem [DEPTH];

    // Status and top-of-stack view used by the jump decision.
    always_comb begin
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        top_data = mem[ptr - PW'(1)];
    end

    // Stack storage, pointer and saturating count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[ptr] <= push_data;
            ptr      <= ptr + PW'(1);
            if (!full) count <= count + CW'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/jump_ctrl.sv
// Jump-side partner of the program counter. Tracks the 6-phase instruction
// window, resolves jump/branch/call/return on the edge leaving phase 5 and
// presents the result to the PC during phase 0.
//
// absjump_en/target interface: absjump_en is a one-cycle qualifier that is
// high only in phase 0; target is meaningful whenever absjump_en is high.
// There is no backpressure: the PC always consumes on the edge ending phase 0.
module jump_ctrl
    import cpu_pkg::*;
#(
    parameter int D         = CPU_D,
    parameter int LUT_AW    = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [D-1:0]      prog_ctr,
    input  logic [2:0]        op,
    input  logic [LUT_AW-1:0] lut_idx,
    input  logic              zero_flag,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [D-1:0]      lut_wdata,
    output logic [2:0]        phase,
    output logic              absjump_en,
    output logic [D-1:0]      target,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    localparam int LUT_N = 2 ** LUT_AW;
    localparam logic [2:0] LAST_PHASE = 3'(PHASES - 1);

    logic [D-1:0] lut [LUT_N];
    logic         sample;
    logic [D-1:0] lut_rd;
    logic         jump_d;
    logic [D-1:0] target_d;
    logic         push, pop, ovf_set, unf_set;
    logic [D-1:0] ret_addr;
    logic [D-1:0] ras_top;
    logic         ras_full, ras_empty;

    ret_stack #(.D(D), .DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (ret_addr),
        .top_data  (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    // Free-running window counter; never stalls so it stays locked to the PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    phase <= '0;
        else if (phase == LAST_PHASE) phase <= '0;
        else                          phase <= phase + 3'd1;
    end

    // Target LUT: writable in any phase, read combinationally so a write on
    // the sampling edge is seen only by the next decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
        end else if (lut_we) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

    // Resolve the current op; RAS side effects only on the sampling edge.
    always_comb begin
        sample   = (phase == LAST_PHASE);
        lut_rd   = lut[lut_idx];
        ret_addr = prog_ctr + D'(1);
        jump_d   = 1'b0;
        target_d = target;
        push     = 1'b0;
        pop      = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        if (sample) begin
            case (op)
                J_JMP: begin
                    jump_d   = 1'b1;
                    target_d = lut_rd;
                end
                J_BEQZ: begin
                    jump_d   = zero_flag;
                    target_d = lut_rd;
                end
                J_BNEZ: begin
                    jump_d   = !zero_flag;
                    target_d = lut_rd;
                end
                J_CALL: begin
                    push     = 1'b1;
                    ovf_set  = ras_full;
                    jump_d   = 1'b1;
                    target_d = lut_rd;
                end
                J_RET: begin
                    if (!ras_empty) begin
                        pop      = 1'b1;
                        jump_d   = 1'b1;
                        target_d = ras_top;
                    end else begin
                        unf_set  = 1'b1;
                    end
                end
                default: jump_d = 1'b0;
            endcase
        end
    end

    // Decision register: result lives for the phase-0 cycle only; flags stick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            absjump_en    <= 1'b0;
            target        <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            if (sample) begin
                absjump_en <= jump_d;
                target     <= target_d;
            end else begin
                absjump_en <= 1'b0;
            end
            ras_overflow  <= ras_overflow | ovf_set;
            ras_underflow <= ras_underflow | unf_set;
        end
    end

endmodule

// File: tb/tb_jump_ctrl.sv
// Bench for jump_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a queue-based model.
module tb_jump_ctrl;
    import cpu_pkg::*;

    localparam int D         = 12;
    localparam int LUT_AW    = 4;
    localparam int RAS_DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [D-1:0]      prog_ctr;
    logic [2:0]        op;
    logic [LUT_AW-1:0] lut_idx;
    logic              zero_flag;
    logic              lut_we;
    logic [LUT_AW-1:0] lut_waddr;
    logic [D-1:0]      lut_wdata;
    logic [2:0]        phase;
    logic              absjump_en;
    logic [D-1:0]      target;
    logic              ras_overflow;
    logic              ras_underflow;

    jump_ctrl #(.D(D), .LUT_AW(LUT_AW), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .prog_ctr      (prog_ctr),
        .op            (op),
        .lut_idx       (lut_idx),
        .zero_flag     (zero_flag),
        .lut_we        (lut_we),
        .lut_waddr     (lut_waddr),
        .lut_wdata     (lut_wdata),
        .phase         (phase),
        .absjump_en    (absjump_en),
        .target        (target),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    int           m_phase;
    logic         m_jump;
    logic [D-1:0] m_target;
    logic         m_ovf, m_unf;
    logic [D-1:0] m_lut [2**LUT_AW];
    logic [D-1:0] exp_q [$];   // return addresses, newest at the back

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_phase  = 0;
        m_jump   = 1'b0;
        m_target = '0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 2**LUT_AW; i++) m_lut[i] = '0;
    endfunction

    // Advance the model across one rising edge using the inputs held over it.
    function automatic void model_edge();
        logic [D-1:0] l;
        logic [D-1:0] ra;
        if (reset) begin
            model_reset();
            return;
        end
        m_jump = 1'b0;
        if (m_phase == PHASES - 1) begin
            l  = m_lut[lut_idx];
            ra = prog_ctr + 12'd1;
            case (op)
                3'd1: begin m_jump = 1'b1;       m_target = l; end
                3'd2: begin m_jump = zero_flag;  m_target = l; end
                3'd3: begin m_jump = !zero_flag; m_target = l; end
                3'd4: begin
                    exp_q.push_back(ra);
                    if (exp_q.size() > RAS_DEPTH) begin
                        void'(exp_q.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_jump   = 1'b1;
                    m_target = l;
                end
                3'd5: begin
                    if (exp_q.size() > 0) begin
                        m_target = exp_q.pop_back();
                        m_jump   = 1'b1;
                    end else begin
                        m_unf = 1'b1;
                    end
                end
                default: m_jump = 1'b0;
            endcase
        end
        if (lut_we) m_lut[lut_waddr] = lut_wdata;
        m_phase = (m_phase + 1) % PHASES;
    endfunction

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("phase",     32'(phase),         32'(m_phase));
            check("absjump",   32'(absjump_en),    32'(m_jump));
            check("target",    32'(target),        32'(m_target));
            check("overflow",  32'(ras_overflow),  32'(m_ovf));
            check("underflow", 32'(ras_underflow), 32'(m_unf));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        op        = 3'd0;
        lut_idx   = '0;
        zero_flag = 1'b0;
        prog_ctr  = '0;
        lut_we    = 1'b0;
        lut_waddr = '0;
        lut_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic lut_write(input logic [LUT_AW-1:0] a, input logic [D-1:0] d);
        lut_we    = 1'b1;
        lut_waddr = a;
        lut_wdata = d;
        tick();
        lut_we    = 1'b0;
    endtask

    // Wait for phase 5, present one op across the sampling edge, then check
    // the phase-0 result against hand-computed values.
    task automatic run_op(input string name, input logic [2:0] o, input logic [LUT_AW-1:0] idx,
                          input logic zf, input logic [D-1:0] pc,
                          input logic we, input logic [LUT_AW-1:0] wa, input logic [D-1:0] wd,
                          input logic ej, input logic [D-1:0] et);
        for (int i = 0; i < PHASES && m_phase != PHASES - 1; i++) tick();
        op        = o;
        lut_idx   = idx;
        zero_flag = zf;
        prog_ctr  = pc;
        lut_we    = we;
        lut_waddr = wa;
        lut_wdata = wd;
        tick();
        idle_inputs();
        check({name, ".phase"},  32'(phase),      32'd0);
        check({name, ".jump"},   32'(absjump_en), 32'(ej));
        check({name, ".target"}, 32'(target),     32'(et));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        cmp_en = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check("rst.phase",  32'(phase),         32'd0);
        check("rst.jump",   32'(absjump_en),    32'd0);
        check("rst.target", 32'(target),        32'd0);
        check("rst.flags",  32'({ras_overflow, ras_underflow}), 32'd0);

        // Idle windows: phase walks 0..5 twice, nothing jumps.
        repeat (12) tick();
        check("idle.phase", 32'(phase), 32'd0);

        // Unconditional jump, then the request drops in phase 1.
        lut_write(4'd3, 12'h2A0);
        run_op("jmp", 3'd1, 4'd3, 1'b0, 12'h000, 1'b0, 4'd0, 12'h000, 1'b1, 12'h2A0);
        tick();
        check("jmp.ph1.jump", 32'(absjump_en), 32'd0);
        check("jmp.ph1",      32'(phase),      32'd1);

        // Conditional branches.
        lut_write(4'd1, 12'h100);
        run_op("beqz1", 3'd2, 4'd1, 1'b1, 12'h000, 1'b0, 4'd0, 12'h000, 1'b1, 12'h100);
        run_op("beqz0", 3'd2, 4'd1, 1'b0, 12'h000, 1'b0, 4'd0, 12'h000, 1'b0, 12'h100);
        run_op("bnez0", 3'd3, 4'd1, 1'b0, 12'h000, 1'b0, 4'd0, 12'h000, 1'b1, 12'h100);
        run_op("bnez1", 3'd3, 4'd1, 1'b1, 12'h000, 1'b0, 4'd0, 12'h000, 1'b0, 12'h100);

        // Nested calls and returns, then an underflowing return.
        run_op("call1", 3'd4, 4'd3, 1'b0, 12'h010, 1'b0, 4'd0, 12'h000, 1'b1, 12'h2A0);
        run_op("call2", 3'd4, 4'd3, 1'b0, 12'h105, 1'b0, 4'd0, 12'h000, 1'b1, 12'h2A0);
        run_op("ret1",  3'd5, 4'd0, 1'b0, 12'h000, 1'b0, 4'd0, 12'h000, 1'b1, 12'h106);
        run_op("ret2",  3'd5, 4'd0, 1'b0, 12'h000, 1'b0, 4'd0, 12'h000, 1'b1, 12'h011);
        run_op("ret3",  3'd5, 4'd0, 1'b0, 12'h000, 1'b0, 4'd0, 12'h000, 1'b0, 12'h011);
        check("unf.set", 32'(ras_underflow), 32'd1);
        repeat (7) tick();
        check("unf.sticky", 32'(ras_underflow), 32'd1);
        check("ovf.clear",  32'(ras_overflow),  32'd0);

        // Overflow: five calls into a four-deep stack keep the newest four.
        for (int i = 1; i <= 5; i++)
            run_op("ovcall", 3'd4, 4'd3, 1'b0, 12'(i), 1'b0, 4'd0, 12'h000, 1'b1, 12'h2A0);
        check("ovf.set", 32'(ras_overflow), 32'd1);
        for (int i = 6; i >= 3; i--)
            run_op("ovret", 3'd5, 4'd0, 1'b0, 12'h000, 1'b0, 4'd0, 12'h000, 1'b1, 12'(i));
        run_op("ovret5", 3'd5, 4'd0, 1'b0, 12'h000, 1'b0, 4'd0, 12'h000, 1'b0, 12'h003);

        // Read-before-write on the sampling edge.
        lut_write(4'd2, 12'h055);
        run_op("rbw.old", 3'd1, 4'd2, 1'b0, 12'h000, 1'b1, 4'd2, 12'h0AA, 1'b1, 12'h055);
        run_op("rbw.new", 3'd1, 4'd2, 1'b0, 12'h000, 1'b0, 4'd0, 12'h000, 1'b1, 12'h0AA);

        // Return address wraps modulo 2**D.
        run_op("wcall", 3'd4, 4'd3, 1'b0, 12'hFFF, 1'b0, 4'd0, 12'h000, 1'b1, 12'h2A0);
        run_op("wret",  3'd5, 4'd0, 1'b0, 12'h000, 1'b0, 4'd0, 12'h000, 1'b1, 12'h000);

        // Reset asserted while a jump request is live in phase 0.
        run_op("prerst", 3'd1, 4'd3, 1'b0, 12'h000, 1'b0, 4'd0, 12'h000, 1'b1, 12'h2A0);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("arst.jump",   32'(absjump_en),   32'd0);
        check("arst.phase",  32'(phase),        32'd0);
        check("arst.target", 32'(target),       32'd0);
        check("arst.ovf",    32'(ras_overflow), 32'd0);
        tick();
        reset = 1'b0;

        // Randomized traffic; only phase-5 values matter but all are varied.
        repeat (600) begin
            op        = 3'($urandom_range(0, 7));
            lut_idx   = LUT_AW'($urandom_range(0, 2**LUT_AW - 1));
            zero_flag = 1'($urandom_range(0, 1));
            prog_ctr  = D'($urandom_range(0, 2**D - 1));
            lut_we    = ($urandom_range(0, 3) == 0);
            lut_waddr = LUT_AW'($urandom_range(0, 2**LUT_AW - 1));
            lut_wdata = D'($urandom_range(0, 2**D - 1));
            tick();
        end
        idle_inputs();
        repeat (6) tick();

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
